// File: rtl/sft_arbiter_pkg.sv
// Shared definitions for the two-requester shift arbiter: op encodings,
// result-register states and default widths.
package sft_arbiter_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_SHAMT_W = 5;

    typedef enum logic [1:0] {
        OP_ZERO = 2'b00,
        OP_SLL  = 2'b01,
        OP_SRL  = 2'b10,
        OP_SRA  = 2'b11
    } op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/sft_arbiter_core.sv
// Combinational shifter shared by both requesters (module sft_core).
module sft_core
    import sft_arbiter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic [DATA_W-1:0]  in,
    input  logic [SHAMT_W-1:0] s,
    input  logic [1:0]         op,
    output logic [DATA_W-1:0]  out
);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        out = '0;
        case (op)
            OP_SLL:  out = in << s;
            OP_SRL:  out = in >> s;
            OP_SRA:  out = DATA_W'($signed(in) >>> s);
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/sft_arbiter.sv
// Two requesters share one shifter through a one-entry result register.
// Define SFT_ARB_FIXED_PRIO_EN to give requester 0 fixed priority instead of round-robin.
module sft_arbiter
    import sft_arbiter_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_in,
    input  logic [SHAMT_W-1:0] req0_s,
    input  logic [1:0]         req0_op,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_in,
    input  logic [SHAMT_W-1:0] req1_s,
    input  logic [1:0]         req1_op,
    output logic               resp_valid,
    output logic               resp_id,
    output logic [DATA_W-1:0]  resp_out,
    input  logic               resp_ready
);

    state_t              state, state_nxt;
    logic                grant;
    logic                accept_ok;
    logic                accept;
    logic [DATA_W-1:0]   mux_in;
    logic [SHAMT_W-1:0]  mux_s;
    logic [1:0]          mux_op;
    logic [DATA_W-1:0]   core_out;

    // Grant looks only at valids and the pointer, never at the readies it produces.
`ifdef SFT_ARB_FIXED_PRIO_EN
    assign grant = req1_valid & ~req0_valid;
`else
    logic last_grant;
    assign grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant;
    end
`endif

    assign mux_in = grant ? req1_in : req0_in;
    assign mux_s  = grant ? req1_s  : req0_s;
    assign mux_op = grant ? req1_op : req0_op;

    sft_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_core (
        .in  (mux_in),
        .s   (mux_s),
        .op  (mux_op),
        .out (core_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (resp_ready && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        resp_valid = (state == FULL);
        accept_ok  = !rst && ((state == EMPTY) || resp_ready);
        req0_ready = accept_ok && req0_valid && !grant;
        req1_ready = accept_ok && req1_valid &&  grant;
        accept     = req0_ready || req1_ready;
    end

    // NOTE: the result register is a single entry, so it is cleared on reset rather than left undefined.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_out <= '0;
            resp_id  <= 1'b0;
        end else if (accept) begin
            resp_out <= core_out;
            resp_id  <= grant;
        end
    end

endmodule
